// File: rtl/uvme_axis_st_chkr_pkg.sv
// -----------------------------------------------------------------------------
// uvme_axis_st_chkr_pkg
// Shared types and width helpers for the AXI-Stream pass-through checker.
//   stbl_state_e : per-port VALID/payload stability FSM state
//   keep_width() : tkeep width for a given tdata width
//   lvl_width()  : width of a 0..DEPTH occupancy counter
// Packages cannot take parameters, so each module declares its payload_t
// struct {tdata, tkeep, tuser, tlast} from its own widths using these helpers.
// -----------------------------------------------------------------------------
package uvme_axis_st_chkr_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } stbl_state_e;

  function automatic int keep_width(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uvme_axis_st_scbd_chkr_if.sv
// -----------------------------------------------------------------------------
// uvme_axis_st_scbd_chkr_if
// One AXI-Stream tap: tvalid, tready, tdata, tkeep, tuser, tlast.
//   master : drives payload and tvalid, receives tready
//   slave  : receives payload and tvalid, drives tready
//   mon    : passive observer, every signal is an input
// -----------------------------------------------------------------------------
interface uvme_axis_st_scbd_chkr_if #(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1
);
  logic                      tvalid;
  logic                      tready;
  logic                      tlast;
  logic [DATA_WIDTH-1:0]     tdata;
  logic [DATA_WIDTH/8-1:0]   tkeep;
  logic [USER_WIDTH-1:0]     tuser;

  modport master (output tvalid, tdata, tkeep, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tuser, tlast, output tready);
  modport mon    (input tvalid, tready, tdata, tkeep, tuser, tlast);
endinterface

// File: rtl/uvme_axis_st_stbl_chkr.sv
// -----------------------------------------------------------------------------
// uvme_axis_st_stbl_chkr
// Stability FSM for one AXI-Stream port. Once valid is seen without ready the
// payload is captured; valid must then stay high and the payload unchanged
// until the handshake.
//   clk, reset_n, clr : clock, async active-low reset, sync clear
//   i_valid, i_ready  : port handshake
//   i_payload         : flattened {tdata, tkeep, tuser, tlast}
//   o_viol            : combinational violation for this cycle (feeds counters)
//   o_err_proto       : registered one-cycle violation pulse
// -----------------------------------------------------------------------------
module uvme_axis_st_stbl_chkr
  import uvme_axis_st_chkr_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = 74
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     i_valid,
  input  logic                     i_ready,
  input  logic [PAYLOAD_WIDTH-1:0] i_payload,
  output logic                     o_viol,
  output logic                     o_err_proto
);

  stbl_state_e              r_state;
  logic [PAYLOAD_WIDTH-1:0] r_cap;
  logic                     r_err_proto;

  // tdata is compared in full here; tkeep does not mask a stability check.
  assign o_viol      = !clr && (r_state == ST_WAIT) &&
                       (!i_valid || (i_payload != r_cap));
  assign o_err_proto = r_err_proto;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cap       <= '0;
      r_err_proto <= 1'b0;
    end else if (clr) begin
      r_state     <= ST_IDLE;
      r_cap       <= '0;
      r_err_proto <= 1'b0;
    end else begin
      r_err_proto <= o_viol;
      case (r_state)
        ST_IDLE: begin
          if (i_valid && !i_ready) begin
            r_cap   <= i_payload;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!i_valid) begin
            r_state <= ST_IDLE;
          end else begin
            // Re-capture so a changed payload is flagged only once.
            if (i_payload != r_cap) r_cap <= i_payload;
            if (i_ready) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uvme_axis_st_scbd_chkr.sv
// -----------------------------------------------------------------------------
// uvme_axis_st_scbd_chkr
// Passive in-order scoreboard for a DUT that forwards AXI-Stream beats
// unchanged. Master beats are queued; each slave beat is compared with the
// oldest queued beat (or with the same-cycle master beat when the queue is
// empty). Both ports are also checked for VALID/payload stability.
//   clk, reset_n, clr          : clock, async active-low reset, sync clear
//   mstr, slv                  : monitored taps (interface, mon modport)
//   err_mismatch/overflow/underflow/proto_mstr/proto_slv : 1-cycle pulses
//   err_sticky                 : any error since reset/clr
//   level                      : queue occupancy
//   pkt_count, err_count       : saturating counters
// -----------------------------------------------------------------------------
module uvme_axis_st_scbd_chkr
  import uvme_axis_st_chkr_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clr,
  uvme_axis_st_scbd_chkr_if.mon         mstr,
  uvme_axis_st_scbd_chkr_if.mon         slv,
  output logic                          err_mismatch,
  output logic                          err_overflow,
  output logic                          err_underflow,
  output logic                          err_proto_mstr,
  output logic                          err_proto_slv,
  output logic                          err_sticky,
  output logic [lvl_width(DEPTH)-1:0]   level,
  output logic [CNT_WIDTH-1:0]          pkt_count,
  output logic [CNT_WIDTH-1:0]          err_count
);

  localparam int KEEP_WIDTH = keep_width(DATA_WIDTH);
  localparam int LVL_WIDTH  = lvl_width(DEPTH);
  localparam int PTR_WIDTH  = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
  } payload_t;

  payload_t               r_mem [DEPTH];
  logic [PTR_WIDTH-1:0]   r_wr_ptr, r_rd_ptr;
  logic [LVL_WIDTH-1:0]   r_level;
  logic [CNT_WIDTH-1:0]   r_pkt_count, r_err_count;
  logic                   r_err_mismatch, r_err_overflow, r_err_underflow;
  logic                   r_err_sticky;

  payload_t w_m_pl, w_s_pl, w_exp;
  logic     w_m_beat, w_s_beat, w_empty, w_full;
  logic     w_push, w_pop, w_cmp, w_mismatch;
  logic     w_mis_nxt, w_ovf_nxt, w_udf_nxt, w_viol_m, w_viol_s, w_any_err;

  assign w_m_pl   = {mstr.tdata, mstr.tkeep, mstr.tuser, mstr.tlast};
  assign w_s_pl   = {slv.tdata, slv.tkeep, slv.tuser, slv.tlast};
  assign w_m_beat = !clr && mstr.tvalid && mstr.tready;
  assign w_s_beat = !clr && slv.tvalid && slv.tready;
  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == LVL_WIDTH'(DEPTH));

  // Empty queue with both beats present bypasses the queue entirely.
  assign w_exp  = w_empty ? w_m_pl : r_mem[r_rd_ptr];
  assign w_cmp  = w_s_beat && (!w_empty || w_m_beat);
  assign w_pop  = w_s_beat && !w_empty;
  assign w_push = w_m_beat && !(w_empty && w_s_beat) && (!w_full || w_s_beat);

  // NOTE: every variable written in always_comb is given a default first so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_mismatch = (w_exp.tkeep != w_s_pl.tkeep) ||
                 (w_exp.tuser != w_s_pl.tuser) ||
                 (w_exp.tlast != w_s_pl.tlast);
    for (int b = 0; b < KEEP_WIDTH; b++) begin
      if (w_exp.tkeep[b] && (w_exp.tdata[8*b +: 8] != w_s_pl.tdata[8*b +: 8]))
        w_mismatch = 1'b1;
    end
  end

  assign w_mis_nxt = w_cmp && w_mismatch;
  assign w_ovf_nxt = w_m_beat && w_full && !w_s_beat;
  assign w_udf_nxt = w_s_beat && w_empty && !w_m_beat;
  assign w_any_err = w_mis_nxt || w_ovf_nxt || w_udf_nxt || w_viol_m || w_viol_s;

  uvme_axis_st_stbl_chkr #(.PAYLOAD_WIDTH($bits(payload_t))) u_stbl_mstr (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (clr),
    .i_valid    (mstr.tvalid),
    .i_ready    (mstr.tready),
    .i_payload  (w_m_pl),
    .o_viol     (w_viol_m),
    .o_err_proto(err_proto_mstr)
  );

  uvme_axis_st_stbl_chkr #(.PAYLOAD_WIDTH($bits(payload_t))) u_stbl_slv (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (clr),
    .i_valid    (slv.tvalid),
    .i_ready    (slv.tready),
    .i_payload  (w_s_pl),
    .o_viol     (w_viol_s),
    .o_err_proto(err_proto_slv)
  );

  // NOTE: the storage array has no reset; occupancy and pointers define which
  // entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_m_pl;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_level         <= '0;
      r_pkt_count     <= '0;
      r_err_count     <= '0;
      r_err_mismatch  <= 1'b0;
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
      r_err_sticky    <= 1'b0;
    end else if (clr) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_level         <= '0;
      r_pkt_count     <= '0;
      r_err_count     <= '0;
      r_err_mismatch  <= 1'b0;
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
      r_err_sticky    <= 1'b0;
    end else begin
      r_err_mismatch  <= w_mis_nxt;
      r_err_overflow  <= w_ovf_nxt;
      r_err_underflow <= w_udf_nxt;
      if (w_any_err) r_err_sticky <= 1'b1;
      if (w_any_err && (r_err_count != '1))
        r_err_count <= r_err_count + CNT_WIDTH'(1);
      if (w_cmp && slv.tlast && (r_pkt_count != '1))
        r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_WIDTH'(1);
        2'b01:   r_level <= r_level - LVL_WIDTH'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign err_mismatch  = r_err_mismatch;
  assign err_overflow  = r_err_overflow;
  assign err_underflow = r_err_underflow;
  assign err_sticky    = r_err_sticky;
  assign level         = r_level;
  assign pkt_count     = r_pkt_count;
  assign err_count     = r_err_count;

endmodule

// File: tb/tb_uvme_axis_st_scbd_chkr.sv
// -----------------------------------------------------------------------------
// tb_uvme_axis_st_scbd_chkr
// Directed bench: a vector table applied one cycle per row, each row carrying
// its hand-computed pulses, level, counters and sticky flag, followed by
// hand-written sequences for async reset, counter saturation and clr.
// DEPTH=4 and CNT_WIDTH=8 keep the full/saturation cases short.
// -----------------------------------------------------------------------------
module tb_uvme_axis_st_scbd_chkr;

  localparam int DW = 64;
  localparam int UW = 1;
  localparam int DP = 4;
  localparam int CW = 8;

  logic          clk;
  logic          reset_n;
  logic          clr;
  logic          err_mismatch, err_overflow, err_underflow;
  logic          err_proto_mstr, err_proto_slv, err_sticky;
  logic [2:0]    level;
  logic [CW-1:0] pkt_count, err_count;

  uvme_axis_st_scbd_chkr_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) m_if ();
  uvme_axis_st_scbd_chkr_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) s_if ();

  uvme_axis_st_scbd_chkr #(
    .DATA_WIDTH(DW), .USER_WIDTH(UW), .DEPTH(DP), .CNT_WIDTH(CW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clr           (clr),
    .mstr          (m_if),
    .slv           (s_if),
    .err_mismatch  (err_mismatch),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_proto_mstr(err_proto_mstr),
    .err_proto_slv (err_proto_slv),
    .err_sticky    (err_sticky),
    .level         (level),
    .pkt_count     (pkt_count),
    .err_count     (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m_v, m_r;
    logic [63:0] m_d;
    logic [7:0]  m_k;
    logic        m_l;
    logic        s_v, s_r;
    logic [63:0] s_d;
    logic [7:0]  s_k;
    logic        s_l;
    logic [4:0]  e_err;   // {mismatch, overflow, underflow, proto_mstr, proto_slv}
    int          e_lvl;
    int          e_pkt;
    int          e_errc;
    logic        e_stk;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(logic mv, logic mr, logic [63:0] md, logic [7:0] mkp,
                              logic ml, logic sv, logic sr, logic [63:0] sd,
                              logic [7:0] sk, logic sl, logic [4:0] ee,
                              int el, int ep, int ec, logic es);
    vec_t v;
    v.m_v = mv; v.m_r = mr; v.m_d = md; v.m_k = mkp; v.m_l = ml;
    v.s_v = sv; v.s_r = sr; v.s_d = sd; v.s_k = sk; v.s_l = sl;
    v.e_err = ee; v.e_lvl = el; v.e_pkt = ep; v.e_errc = ec; v.e_stk = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_m(input logic v, input logic r, input logic [63:0] d,
                         input logic [7:0] k, input logic l);
    m_if.tvalid = v; m_if.tready = r; m_if.tdata = d;
    m_if.tkeep = k; m_if.tuser = '0; m_if.tlast = l;
  endtask

  task automatic drive_s(input logic v, input logic r, input logic [63:0] d,
                         input logic [7:0] k, input logic l);
    s_if.tvalid = v; s_if.tready = r; s_if.tdata = d;
    s_if.tkeep = k; s_if.tuser = '0; s_if.tlast = l;
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] err_bits();
    return {err_mismatch, err_overflow, err_underflow, err_proto_mstr, err_proto_slv};
  endfunction

  initial begin
    localparam logic [63:0] KD  = 64'h11223344_55667788;
    localparam logic [63:0] KDS = 64'hFFFFFFFF_55667788;

    // Phase 1: four beats at one-cycle skew, one packet.
    vecs.push_back(mk(1,1,64'hA0,8'hFF,0, 0,0,64'h0,8'h00,0, 5'b00000, 1,0,0,0));
    vecs.push_back(mk(1,1,64'hA1,8'hFF,0, 1,1,64'hA0,8'hFF,0, 5'b00000, 1,0,0,0));
    vecs.push_back(mk(1,1,64'hA2,8'hFF,0, 1,1,64'hA1,8'hFF,0, 5'b00000, 1,0,0,0));
    vecs.push_back(mk(1,1,64'hA3,8'hFF,1, 1,1,64'hA2,8'hFF,0, 5'b00000, 1,0,0,0));
    vecs.push_back(mk(0,0,64'h0,8'h00,0, 1,1,64'hA3,8'hFF,1, 5'b00000, 0,1,0,0));
    // Phase 2: tkeep-masked compare, then tkeep mismatch.
    vecs.push_back(mk(1,1,KD,8'h0F,1, 0,0,64'h0,8'h00,0, 5'b00000, 1,1,0,0));
    vecs.push_back(mk(0,0,64'h0,8'h00,0, 1,1,KDS,8'h0F,1, 5'b00000, 0,2,0,0));
    vecs.push_back(mk(1,1,KD,8'h0F,1, 0,0,64'h0,8'h00,0, 5'b00000, 1,2,0,0));
    vecs.push_back(mk(0,0,64'h0,8'h00,0, 1,1,KD,8'hFF,1, 5'b10000, 0,3,1,1));
    // Phase 3: fill to DEPTH, overflow, full push+pop, drain, underflow.
    vecs.push_back(mk(1,1,64'hB0,8'hFF,0, 0,0,64'h0,8'h00,0, 5'b00000, 1,3,1,1));
    vecs.push_back(mk(1,1,64'hB1,8'hFF,0, 0,0,64'h0,8'h00,0, 5'b00000, 2,3,1,1));
    vecs.push_back(mk(1,1,64'hB2,8'hFF,0, 0,0,64'h0,8'h00,0, 5'b00000, 3,3,1,1));
    vecs.push_back(mk(1,1,64'hB3,8'hFF,0, 0,0,64'h0,8'h00,0, 5'b00000, 4,3,1,1));
    vecs.push_back(mk(1,1,64'hB4,8'hFF,0, 0,0,64'h0,8'h00,0, 5'b01000, 4,3,2,1));
    vecs.push_back(mk(1,1,64'hB5,8'hFF,0, 1,1,64'hB0,8'hFF,0, 5'b00000, 4,3,2,1));
    vecs.push_back(mk(0,0,64'h0,8'h00,0, 1,1,64'hB1,8'hFF,0, 5'b00000, 3,3,2,1));
    vecs.push_back(mk(0,0,64'h0,8'h00,0, 1,1,64'hB2,8'hFF,0, 5'b00000, 2,3,2,1));
    vecs.push_back(mk(0,0,64'h0,8'h00,0, 1,1,64'hB3,8'hFF,0, 5'b00000, 1,3,2,1));
    vecs.push_back(mk(0,0,64'h0,8'h00,0, 1,1,64'hB5,8'hFF,0, 5'b00000, 0,3,2,1));
    vecs.push_back(mk(0,0,64'h0,8'h00,0, 1,1,64'hDEAD,8'hFF,1, 5'b00100, 0,3,3,1));
    // Phase 4: bypass on empty queue.
    vecs.push_back(mk(1,1,64'hC0,8'hFF,1, 1,1,64'hC0,8'hFF,1, 5'b00000, 0,4,3,1));
    // Phase 5: slave payload change on handshake with empty queue -> two
    // pulses in one cycle, err_count +1.
    vecs.push_back(mk(0,0,64'h0,8'h00,0, 1,0,64'hE0,8'hFF,0, 5'b00000, 0,4,3,1));
    vecs.push_back(mk(0,0,64'h0,8'h00,0, 1,1,64'hE1,8'hFF,0, 5'b00101, 0,4,4,1));
    // Phase 6: master stalled 3 cycles, tdata changes in cycle 2.
    vecs.push_back(mk(1,0,64'hF0,8'hFF,0, 0,0,64'h0,8'h00,0, 5'b00000, 0,4,4,1));
    vecs.push_back(mk(1,0,64'hF1,8'hFF,0, 0,0,64'h0,8'h00,0, 5'b00010, 0,4,5,1));
    vecs.push_back(mk(1,0,64'hF1,8'hFF,0, 0,0,64'h0,8'h00,0, 5'b00000, 0,4,5,1));
    vecs.push_back(mk(1,1,64'hF1,8'hFF,0, 0,0,64'h0,8'h00,0, 5'b00000, 1,4,5,1));
    // Phase 7: slave drops valid before ready.
    vecs.push_back(mk(0,0,64'h0,8'h00,0, 1,0,64'hF1,8'hFF,0, 5'b00000, 1,4,5,1));
    vecs.push_back(mk(0,0,64'h0,8'h00,0, 0,0,64'h0,8'h00,0, 5'b00001, 1,4,6,1));
    vecs.push_back(mk(0,0,64'h0,8'h00,0, 1,1,64'hF1,8'hFF,0, 5'b00000, 0,4,6,1));

    // Reset state.
    reset_n = 1'b0;
    clr     = 1'b0;
    drive_m(0, 0, 64'h0, 8'h00, 0);
    drive_s(0, 0, 64'h0, 8'h00, 0);
    step();
    step();
    check("reset err", 64'(err_bits()), 64'd0);
    check("reset lvl", 64'(level), 64'd0);
    check("reset cnt", {32'(pkt_count), 32'(err_count)}, 64'd0);
    check("reset stk", 64'(err_sticky), 64'd0);
    reset_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      drive_m(vecs[i].m_v, vecs[i].m_r, vecs[i].m_d, vecs[i].m_k, vecs[i].m_l);
      drive_s(vecs[i].s_v, vecs[i].s_r, vecs[i].s_d, vecs[i].s_k, vecs[i].s_l);
      step();
      check($sformatf("row%0d err", i),  64'(err_bits()),  64'(vecs[i].e_err));
      check($sformatf("row%0d lvl", i),  64'(level),       64'(vecs[i].e_lvl));
      check($sformatf("row%0d pkt", i),  64'(pkt_count),   64'(vecs[i].e_pkt));
      check($sformatf("row%0d errc", i), 64'(err_count),   64'(vecs[i].e_errc));
      check($sformatf("row%0d stk", i),  64'(err_sticky),  64'(vecs[i].e_stk));
    end

    // Async reset mid-packet with three beats queued.
    drive_s(0, 0, 64'h0, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      drive_m(1, 1, 64'h100 + 64'(i), 8'hFF, 0);
      step();
    end
    drive_m(0, 0, 64'h0, 8'h00, 0);
    check("mid lvl", 64'(level), 64'd3);
    reset_n = 1'b0;
    #1;
    check("async lvl", 64'(level), 64'd0);
    check("async cnt", {32'(pkt_count), 32'(err_count)}, 64'd0);
    check("async stk", 64'(err_sticky), 64'd0);
    #2;
    reset_n = 1'b1;
    step();
    check("post-rst err", 64'(err_bits()), 64'd0);
    check("post-rst errc", 64'(err_count), 64'd0);

    // Saturate err_count with back-to-back underflows.
    drive_s(1, 1, 64'h55, 8'hFF, 0);
    for (int i = 0; i < 260; i++) step();
    check("sat errc", 64'(err_count), 64'hFF);
    step();
    check("sat udf", 64'(err_underflow), 64'd1);
    check("sat hold", 64'(err_count), 64'hFF);
    check("sat stk", 64'(err_sticky), 64'd1);

    // Queue two beats, then clr with beats on both ports.
    drive_s(0, 0, 64'h0, 8'h00, 0);
    drive_m(1, 1, 64'h200, 8'hFF, 0);
    step();
    step();
    check("pre-clr lvl", 64'(level), 64'd2);
    clr = 1'b1;
    drive_s(1, 1, 64'h999, 8'hFF, 1);
    step();
    check("clr lvl", 64'(level), 64'd0);
    check("clr cnt", {32'(pkt_count), 32'(err_count)}, 64'd0);
    check("clr stk", 64'(err_sticky), 64'd0);
    check("clr err", 64'(err_bits()), 64'd0);
    clr = 1'b0;
    drive_m(0, 0, 64'h0, 8'h00, 0);
    step();
    check("after-clr udf", 64'(err_underflow), 64'd1);
    check("after-clr errc", 64'(err_count), 64'd1);
    check("after-clr pkt", 64'(pkt_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
